// File: rtl/wb_queue_pkg.sv
// Shared constants and types for the write-back queue.
package wb_pkg;

    localparam int WB_WIDTH   = 8;
    localparam int WB_REGBITS = 3;
    localparam int WB_DEPTH   = 4;

    // One pending register write at the default widths.
    typedef struct packed {
        logic [WB_REGBITS-1:0] addr;
        logic [WB_WIDTH-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue_if.sv
// Producer / register-file / bypass signal bundle for wb_queue.
interface wb_queue_if #(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3,
    parameter int DEPTH   = 4
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic               in_valid;
    logic               in_ready;
    logic [REGBITS-1:0] in_addr;
    logic [WIDTH-1:0]   in_data;
    logic               hold;
    logic               regwrite;
    logic [REGBITS-1:0] wa;
    logic [WIDTH-1:0]   wd;
    logic [REGBITS-1:0] ra1;
    logic [REGBITS-1:0] ra2;
    logic               hit1;
    logic               hit2;
    logic [WIDTH-1:0]   bd1;
    logic [WIDTH-1:0]   bd2;
    logic [CW-1:0]      count;

    // Queue side.
    modport slave (
        input  in_valid, in_addr, in_data, hold, ra1, ra2,
        output in_ready, regwrite, wa, wd, hit1, hit2, bd1, bd2, count
    );

    // Producer / pipeline side.
    modport master (
        output in_valid, in_addr, in_data, hold, ra1, ra2,
        input  in_ready, regwrite, wa, wd, hit1, hit2, bd1, bd2, count
    );
endinterface

// File: rtl/wb_queue_bypass.sv
// Single bypass lookup port: finds the newest occupied entry whose address
// matches ra, scanning from the slot just behind the tail towards the head.
module wbq_bypass #(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3,
    parameter int DEPTH   = 4
) (
    input  logic [REGBITS-1:0]         addr_mem [DEPTH],
    input  logic [WIDTH-1:0]           data_mem [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   tail,
    input  logic [$clog2(DEPTH+1)-1:0] count,
    input  logic [REGBITS-1:0]         ra,
    output logic                       hit,
    output logic [WIDTH-1:0]           bd
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Age k = 0 is the newest entry; the first match found wins.
    always_comb begin
        logic [PW-1:0] idx;
        hit = 1'b0;
        bd  = '0;
        idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = tail - PW'(k + 1);
            if (!hit && (ra != '0) && (CW'(k) < count) && (addr_mem[idx] == ra)) begin
                hit = 1'b1;
                bd  = data_mem[idx];
            end
        end
    end
endmodule

// File: rtl/wb_queue.sv
// Write-back queue in front of the register-file write port.
// Optional feature macro: WBQ_BYPASS_EN builds the two bypass lookup ports;
// without it hit1/hit2/bd1/bd2 are tied to 0 and ra1/ra2 are ignored.
module wb_queue
    import wb_pkg::*;
#(
    parameter int WIDTH   = WB_WIDTH,
    parameter int REGBITS = WB_REGBITS,
    parameter int DEPTH   = WB_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    wb_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [REGBITS-1:0] addr_mem [DEPTH];
    logic [WIDTH-1:0]   data_mem [DEPTH];
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [CW-1:0]      count_q;

    logic in_ready;
    logic enq;
    logic deq;

    // Handshake and issue decode. Writes to register 0 are accepted and dropped.
    always_comb begin
        in_ready = (count_q != CW'(DEPTH));
        enq      = bus.in_valid && in_ready && (bus.in_addr != '0);
        deq      = (count_q != '0) && !bus.hold;
    end

    assign bus.in_ready = in_ready;
    assign bus.regwrite = deq;
    assign bus.wa       = deq ? addr_mem[head] : '0;
    assign bus.wd       = deq ? data_mem[head] : '0;
    assign bus.count    = count_q;

    // Circular buffer storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (enq) begin
                addr_mem[tail] <= bus.in_addr;
                data_mem[tail] <= bus.in_data;
                tail           <= tail + PW'(1);
            end
            if (deq) begin
                head <= head + PW'(1);
            end
            count_q <= count_q + CW'(enq) - CW'(deq);
        end
    end

`ifdef WBQ_BYPASS_EN
    wbq_bypass #(.WIDTH(WIDTH), .REGBITS(REGBITS), .DEPTH(DEPTH)) u_byp1 (
        .addr_mem (addr_mem),
        .data_mem (data_mem),
        .tail     (tail),
        .count    (count_q),
        .ra       (bus.ra1),
        .hit      (bus.hit1),
        .bd       (bus.bd1)
    );

    wbq_bypass #(.WIDTH(WIDTH), .REGBITS(REGBITS), .DEPTH(DEPTH)) u_byp2 (
        .addr_mem (addr_mem),
        .data_mem (data_mem),
        .tail     (tail),
        .count    (count_q),
        .ra       (bus.ra2),
        .hit      (bus.hit2),
        .bd       (bus.bd2)
    );
`else
    logic unused_ra;
    assign unused_ra = ^{bus.ra1, bus.ra2};
    assign bus.hit1  = 1'b0;
    assign bus.hit2  = 1'b0;
    assign bus.bd1   = '0;
    assign bus.bd2   = '0;
`endif
endmodule
